ultrasonic_ranger_multi: RTL and testbench

Parametrised multi-channel successor to the single-sensor trigger/echo path. Fires TRIG pulses to N_CH ultrasonic sensors round-robin, measures each echo width in centimetres with saturation and timeout, and publishes per-channel distance registers plus a per-sample strobe. Sits between the sensor pins and the BCD/7-segment display path.

---
 rtl/ultrasonic_ranger_multi_pkg.sv | 26 ++
 rtl/ultrasonic_ranger_multi_echo_width_counter.sv | 56 +++++
 rtl/ultrasonic_ranger_multi.sv | 192 +++++++++++++++++++
 tb/tb_ultrasonic_ranger_multi.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_ranger_multi_pkg.sv
// Shared types and default 25 MHz timing for the multi-channel ranger.
// State encoding, channel index width and a counter-width helper.
package ultrasonic_ranger_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE,
    ST_GAP
  } state_t;

  localparam int CH_W            = 3;
  localparam int DEF_N_CH        = 2;
  localparam int DEF_DIST_W      = 9;
  localparam int DEF_TRIG_CYC    = 250;
  localparam int DEF_CM_CYC      = 1450;
  localparam int DEF_TIMEOUT_CYC = 750000;
  localparam int DEF_GAP_CYC     = 1500000;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_multi_echo_width_counter.sv
// Echo width counter: cycle sub-counter, saturating cm count and timeout.
// Cleared during the trigger pulse, runs while waiting for / measuring echo.
module echo_width_counter
  import ultrasonic_ranger_multi_pkg::*;
#(
  parameter int DIST_W      = DEF_DIST_W,
  parameter int CM_CYC      = DEF_CM_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              run,
  input  logic              echo_hi,
  output logic [DIST_W-1:0] cm,
  output logic              expired
);

  localparam int SUB_W = cnt_w(CM_CYC);
  localparam int TO_W  = cnt_w(TIMEOUT_CYC);

  logic [SUB_W-1:0] sub;
  logic [TO_W-1:0]  to_cnt;

  assign expired = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Timeout counter: holds once expired so the FSM sees a stable flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (clr) begin
      to_cnt <= '0;
    end else if (run && !expired) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Count echo-high cycles; every CM_CYC cycles adds one saturating cm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub <= '0;
      cm  <= '0;
    end else if (clr) begin
      sub <= '0;
      cm  <= '0;
    end else if (run && echo_hi) begin
      if (sub == SUB_W'(CM_CYC - 1)) begin
        sub <= '0;
        if (cm != '1) cm <= cm + 1'b1;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ultrasonic_ranger_multi.sv
// Round-robin multi-channel ultrasonic ranger with per-channel distances.
// Optional RANGER_ALERT_EN adds a threshold input and per-channel alerts.
module ultrasonic_ranger_multi
  import ultrasonic_ranger_multi_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DIST_W      = DEF_DIST_W,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int CM_CYC      = DEF_CM_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   single_shot,
  input  logic                   start,
  input  logic [N_CH-1:0]        echo,
`ifdef RANGER_ALERT_EN
  input  logic [DIST_W-1:0]      threshold,
`endif
  output logic [N_CH-1:0]        trigger,
  output logic                   busy,
  output logic                   sample_stb,
  output logic [CH_W-1:0]        sample_ch,
  output logic                   sample_timeout,
  output logic [N_CH*DIST_W-1:0] dist_flat,
  output logic [N_CH-1:0]        alert
);

  localparam int PH_MAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
  localparam int PH_W   = cnt_w(PH_MAX);

  state_t            state, state_d;
  logic [CH_W-1:0]   ch, ch_d;
  logic [PH_W-1:0]   ph;
  logic              to_flag, to_flag_d;
  logic [N_CH-1:0]   sync1, sync2;
  logic              echo_act;
  logic [N_CH-1:0]   trig_d;
  logic [DIST_W-1:0] cm;
  logic              expired;
  logic              cnt_clr, cnt_run;

  // Two-flop synchroniser on every echo line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
    end
  end

  // Pick the active channel's synchronised echo.
  always_comb begin
    echo_act = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch == CH_W'(i)) echo_act = sync2[i];
    end
  end

  assign cnt_clr = (state == ST_TRIG);
  assign cnt_run = (state == ST_WAIT_RISE) || (state == ST_MEASURE);

  echo_width_counter #(
    .DIST_W      (DIST_W),
    .CM_CYC      (CM_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .run     (cnt_run),
    .echo_hi (echo_act),
    .cm      (cm),
    .expired (expired)
  );

  // Sequencer next-state, channel advance and timeout flag.
  always_comb begin
    state_d   = state;
    ch_d      = ch;
    to_flag_d = to_flag;
    unique case (state)
      ST_IDLE: begin
        if (enable && (!single_shot || start)) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        to_flag_d = 1'b0;
        if (ph == PH_W'(TRIG_CYC - 1)) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (echo_act) begin
          state_d = ST_MEASURE;
        end else if (expired) begin
          state_d   = ST_DONE;
          to_flag_d = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_act) begin
          state_d = ST_DONE;
        end else if (expired) begin
          state_d   = ST_DONE;
          to_flag_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (ph == PH_W'(GAP_CYC - 1)) begin
          if (ch == CH_W'(N_CH - 1)) ch_d = '0;
          else                       ch_d = ch + 1'b1;
          if ((ch == CH_W'(N_CH - 1) && single_shot) || !enable)
            state_d = ST_IDLE;
          else
            state_d = ST_TRIG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Trigger bit for the upcoming cycle, so the pin comes straight off a flop.
  always_comb begin
    trig_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      trig_d[i] = (state_d == ST_TRIG) && (ch_d == CH_W'(i));
    end
  end

  // State, channel and phase counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ch      <= '0;
      ph      <= '0;
      to_flag <= 1'b0;
      trigger <= '0;
    end else begin
      state   <= state_d;
      ch      <= ch_d;
      to_flag <= to_flag_d;
      trigger <= trig_d;
      if (state_d != state)
        ph <= '0;
      else if (state == ST_TRIG || state == ST_GAP)
        ph <= ph + 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  // Publish the sample from DONE; strobe lines up with the new data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_stb     <= 1'b0;
      sample_ch      <= '0;
      sample_timeout <= 1'b0;
      dist_flat      <= '0;
    end else begin
      sample_stb <= (state == ST_DONE);
      if (state == ST_DONE) begin
        sample_ch      <= ch;
        sample_timeout <= to_flag;
        for (int i = 0; i < N_CH; i++) begin
          if (ch == CH_W'(i))
            dist_flat[i*DIST_W +: DIST_W] <= to_flag ? '1 : cm;
        end
      end
    end
  end

`ifdef RANGER_ALERT_EN
  // Alert follows the latest valid distance; a timeout clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alert <= '0;
    end else if (state == ST_DONE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch == CH_W'(i)) alert[i] <= !to_flag && (cm < threshold);
      end
    end
  end
`else
  assign alert = '0;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// Directed bench for ultrasonic_ranger_multi with a small sensor responder.
// Covers pulse width, cm scaling, timeout, saturation, ordering, single-shot, reset.
module tb_ultrasonic_ranger_multi;

  localparam int N_CH        = 2;
  localparam int DIST_W      = 8;
  localparam int TRIG_CYC    = 5;
  localparam int CM_CYC      = 10;
  localparam int TIMEOUT_CYC = 4000;
  localparam int GAP_CYC     = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        single_shot;
  logic        start;
  logic [1:0]  echo = '0;
`ifdef RANGER_ALERT_EN
  logic [7:0]  threshold;
`endif
  logic [1:0]  trigger;
  logic        busy;
  logic        sample_stb;
  logic [2:0]  sample_ch;
  logic        sample_timeout;
  logic [15:0] dist_flat;
  logic [1:0]  alert;

  ultrasonic_ranger_multi #(
    .N_CH        (N_CH),
    .DIST_W      (DIST_W),
    .TRIG_CYC    (TRIG_CYC),
    .CM_CYC      (CM_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (GAP_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .single_shot    (single_shot),
    .start          (start),
    .echo           (echo),
`ifdef RANGER_ALERT_EN
    .threshold      (threshold),
`endif
    .trigger        (trigger),
    .busy           (busy),
    .sample_stb     (sample_stb),
    .sample_ch      (sample_ch),
    .sample_timeout (sample_timeout),
    .dist_flat      (dist_flat),
    .alert          (alert)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sensor model: after a trigger falls, wait dly cycles, then echo wid cycles.
  int dly [2];
  int wid [2];
  int cd  [2];
  int ph  [2] = '{0, 0};
  logic [1:0] tprev = '0;

  always @(negedge clk) begin
    if (!reset) begin
      echo  = '0;
      ph    = '{0, 0};
      tprev = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ph[i] == 1) begin
          if (cd[i] == 0) begin
            echo[i] = 1'b1;
            cd[i]   = wid[i];
            ph[i]   = 2;
          end else begin
            cd[i]--;
          end
        end else if (ph[i] == 2) begin
          cd[i]--;
          if (cd[i] == 0) begin
            echo[i] = 1'b0;
            ph[i]   = 0;
          end
        end
        if (tprev[i] && !trigger[i] && wid[i] > 0) begin
          ph[i] = 1;
          cd[i] = dly[i];
        end
      end
      tprev = trigger;
    end
  end

  // Record trigger rises, multi-hot triggers and sample strobes.
  int trig_q[$];
  int stb_q[$];
  int multi_hot = 0;
  logic [1:0] mprev = '0;

  always @(negedge clk) begin
    if ($countones(trigger) > 1) multi_hot++;
    for (int i = 0; i < 2; i++) begin
      if (trigger[i] && !mprev[i]) trig_q.push_back(i);
    end
    mprev = trigger;
    if (sample_stb) stb_q.push_back(int'(sample_ch));
  end

  int n;
  int code;

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    single_shot = 1'b0;
    start       = 1'b0;
    dly         = '{30, 30};
    wid         = '{250, 0};
`ifdef RANGER_ALERT_EN
    threshold   = 8'd50;
`endif
    repeat (3) @(negedge clk);
    chk("rst_trigger", trigger, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stb", sample_stb, 1'b0);
    chk("rst_dist", dist_flat, 16'h0000);
    chk("rst_ch", sample_ch, 3'd0);
    chk("rst_to", sample_timeout, 1'b0);
    chk("rst_alert", alert, 2'b00);

    enable = 1'b1;
    reset  = 1'b1;

    for (n = 0; n < 50 && !trigger[0]; n++) @(negedge clk);
    chk("trig0_rise", trigger, 2'b01);
    n = 0;
    while (trigger[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("trig0_width", n, TRIG_CYC);

    for (n = 0; n < 6000 && !sample_stb; n++) @(negedge clk);
    chk("s0_stb", sample_stb, 1'b1);
    chk("s0_ch", sample_ch, 3'd0);
    chk("s0_to", sample_timeout, 1'b0);
    chk("s0_dist", dist_flat[7:0], 8'd25);

    for (n = 0; n < 100 && !trigger[1]; n++) @(negedge clk);
    chk("trig1_rise", trigger, 2'b10);
    for (n = 0; n < 50 && trigger[1]; n++) @(negedge clk);
    for (n = 0; n < 6000 && !sample_stb; n++) @(negedge clk);
    chk("s1_to_lat", n, TIMEOUT_CYC + 1);
    chk("s1_ch", sample_ch, 3'd1);
    chk("s1_to", sample_timeout, 1'b1);
    chk("s1_dist", dist_flat, 16'hff19);

    wid = '{3000, 120};
    for (n = 0; n < 100 && !trigger[0]; n++) @(negedge clk);
    chk("gap_len", n, GAP_CYC);

    for (n = 0; n < 6000 && !sample_stb; n++) @(negedge clk);
    chk("s2_ch", sample_ch, 3'd0);
    chk("s2_to", sample_timeout, 1'b0);
    chk("s2_sat", dist_flat[7:0], 8'hff);
    @(negedge clk);
    for (n = 0; n < 6000 && !sample_stb; n++) @(negedge clk);
    chk("s3_ch", sample_ch, 3'd1);
    chk("s3_to", sample_timeout, 1'b0);
    chk("s3_dist", dist_flat, 16'h0cff);
`ifdef RANGER_ALERT_EN
    chk("s3_alert", alert, 2'b10);
`else
    chk("s3_alert", alert, 2'b00);
`endif
    code = (trig_q.size() >= 4) ?
      trig_q[0] * 1000 + trig_q[1] * 100 + trig_q[2] * 10 + trig_q[3] : -1;
    chk("trig_order", code, 101);
    chk("trig_cnt", trig_q.size(), 4);

    enable = 1'b0;
    for (n = 0; n < 200 && busy; n++) @(negedge clk);
    chk("stop_busy", busy, 1'b0);

    wid         = '{100, 70};
    single_shot = 1'b1;
    enable      = 1'b1;
    repeat (5) @(negedge clk);
    chk("ss_idle", busy, 1'b0);
    stb_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("ss_busy", busy, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 3000 && busy; n++) @(negedge clk);
    chk("ss_done", busy, 1'b0);
    chk("ss_nstb", stb_q.size(), 2);
    code = (stb_q.size() >= 2) ? stb_q[0] * 10 + stb_q[1] : -1;
    chk("ss_order", code, 1);
    chk("ss_dist", dist_flat, 16'h070a);
`ifdef RANGER_ALERT_EN
    chk("ss_alert", alert, 2'b11);
`else
    chk("ss_alert", alert, 2'b00);
`endif
    repeat (200) @(negedge clk);
    chk("ss_stay_idle", busy, 1'b0);
    chk("ss_nstb_after", stb_q.size(), 2);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 200 && !echo[0]; n++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rst2_trigger", trigger, 2'b00);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_dist", dist_flat, 16'h0000);
    chk("rst2_stb", sample_stb, 1'b0);
    @(negedge clk);
    single_shot = 1'b0;
    reset       = 1'b1;
    for (n = 0; n < 100 && trigger == 2'b00; n++) @(negedge clk);
    chk("restart_ch0", trigger, 2'b01);

    chk("one_hot", multi_hot, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
